// File: rtl/collatz_stepper.sv
// Sequential Collatz (3n+1) engine: loads a seed, applies one halve/3n+1 transform per clock until 1.
// Optional macro COLLATZ_PEAK_EN adds a 'peak' output tracking the largest value reached in a run.
module collatz_stepper #(
    parameter int N = 8,
    parameter int W = 16,
    parameter int S = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] seed,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] value,
    output logic [S-1:0] steps,
    output logic         err
`ifdef COLLATZ_PEAK_EN
    ,output logic [W-1:0] peak
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_r, state_s;
    logic [W-1:0]   value_r, value_s;
    logic [S-1:0]   steps_r, steps_s;
    logic           err_r, err_s;
    logic           busy_r, done_r;
    logic [W+1:0]   triple_s;
    logic           overflow_s;
    logic           value_one_s;
    logic           steps_sat_s;
`ifdef COLLATZ_PEAK_EN
    logic [W-1:0]   peak_r, peak_s;
`endif

    // 3*value+1 evaluated two bits wider so an overflow of the value register is visible
    always_comb begin
        triple_s    = ({2'b00, value_r} << 1) + {2'b00, value_r} + {{(W+1){1'b0}}, 1'b1};
        overflow_s  = |triple_s[W+1:W];
        value_one_s = (value_r == {{(W-1){1'b0}}, 1'b1});
        steps_sat_s = (steps_r == {S{1'b1}});
    end

    // Next-state and datapath update; checks in RUN are ordered: reached 1, saturation, parity
    always_comb begin
        state_s = state_r;
        value_s = value_r;
        steps_s = steps_r;
        err_s   = err_r;
`ifdef COLLATZ_PEAK_EN
        peak_s  = peak_r;
`endif
        case (state_r)
            IDLE: begin
                if (start) begin
                    value_s = {{(W-N){1'b0}}, seed};
                    steps_s = {S{1'b0}};
`ifdef COLLATZ_PEAK_EN
                    peak_s  = {{(W-N){1'b0}}, seed};
`endif
                    if (seed == {N{1'b0}}) begin
                        err_s   = 1'b1;
                        state_s = DONE;
                    end else begin
                        err_s   = 1'b0;
                        state_s = RUN;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (value_one_s) begin
                    state_s = DONE;
                end else if (steps_sat_s) begin
                    err_s   = 1'b1;
                    state_s = DONE;
                end else if (!value_r[0]) begin
                    // halving can never raise the peak, so peak is left alone here
                    value_s = value_r >> 1;
                    steps_s = steps_r + {{(S-1){1'b0}}, 1'b1};
                end else if (overflow_s) begin
                    err_s   = 1'b1;
                    state_s = DONE;
                end else begin
                    value_s = triple_s[W-1:0];
                    steps_s = steps_r + {{(S-1){1'b0}}, 1'b1};
`ifdef COLLATZ_PEAK_EN
                    if (triple_s[W-1:0] > peak_r) begin
                        peak_s = triple_s[W-1:0];
                    end else begin
                        peak_s = peak_r;
                    end
`endif
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and output registers; busy/done are decoded from the next state so they align with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            value_r <= {W{1'b0}};
            steps_r <= {S{1'b0}};
            err_r   <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
`ifdef COLLATZ_PEAK_EN
            peak_r  <= {W{1'b0}};
`endif
        end else begin
            state_r <= state_s;
            value_r <= value_s;
            steps_r <= steps_s;
            err_r   <= err_s;
            busy_r  <= (state_s == RUN);
            done_r  <= (state_s == DONE);
`ifdef COLLATZ_PEAK_EN
            peak_r  <= peak_s;
`endif
        end
    end

    assign busy  = busy_r;
    assign done  = done_r;
    assign value = value_r;
    assign steps = steps_r;
    assign err   = err_r;
`ifdef COLLATZ_PEAK_EN
    assign peak  = peak_r;
`endif

endmodule

// File: tb/tb_collatz_stepper.sv
// Scoreboard bench for collatz_stepper: default, W=8 and S=4 instances against a behavioural Collatz model.
module tb_collatz_stepper;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start_a [3];
    logic [7:0]  seed_a  [3];
    logic        busy_a  [3];
    logic        done_a  [3];
    logic        err_a   [3];
    logic [15:0] value_a [3];
    logic [7:0]  steps_a [3];
    logic [15:0] peak_a  [3];

    logic        busy_m, done_m, err_m;
    logic [15:0] value_m;
    logic [7:0]  steps_m;
    logic        busy_w, done_w, err_w;
    logic [7:0]  value_w;
    logic [7:0]  steps_w;
    logic        busy_s, done_s, err_s;
    logic [15:0] value_s;
    logic [3:0]  steps_s;
`ifdef COLLATZ_PEAK_EN
    logic [15:0] peak_m;
    logic [7:0]  peak_w;
    logic [15:0] peak_s;
`endif

    collatz_stepper #(.N(8), .W(16), .S(8)) dut_main (
        .clk(clk), .rst_n(rst_n), .start(start_a[0]), .seed(seed_a[0]),
        .busy(busy_m), .done(done_m), .value(value_m), .steps(steps_m), .err(err_m)
`ifdef COLLATZ_PEAK_EN
        , .peak(peak_m)
`endif
    );

    collatz_stepper #(.N(6), .W(8), .S(8)) dut_w8 (
        .clk(clk), .rst_n(rst_n), .start(start_a[1]), .seed(seed_a[1][5:0]),
        .busy(busy_w), .done(done_w), .value(value_w), .steps(steps_w), .err(err_w)
`ifdef COLLATZ_PEAK_EN
        , .peak(peak_w)
`endif
    );

    collatz_stepper #(.N(8), .W(16), .S(4)) dut_s4 (
        .clk(clk), .rst_n(rst_n), .start(start_a[2]), .seed(seed_a[2]),
        .busy(busy_s), .done(done_s), .value(value_s), .steps(steps_s), .err(err_s)
`ifdef COLLATZ_PEAK_EN
        , .peak(peak_s)
`endif
    );

    always_comb begin
        busy_a[0] = busy_m;  done_a[0] = done_m;  err_a[0] = err_m;
        busy_a[1] = busy_w;  done_a[1] = done_w;  err_a[1] = err_w;
        busy_a[2] = busy_s;  done_a[2] = done_s;  err_a[2] = err_s;
        value_a[0] = value_m;
        value_a[1] = {8'd0, value_w};
        value_a[2] = value_s;
        steps_a[0] = steps_m;
        steps_a[1] = steps_w;
        steps_a[2] = {4'd0, steps_s};
`ifdef COLLATZ_PEAK_EN
        peak_a[0] = peak_m;
        peak_a[1] = {8'd0, peak_w};
        peak_a[2] = peak_s;
`else
        peak_a[0] = 16'd0;
        peak_a[1] = 16'd0;
        peak_a[2] = 16'd0;
`endif
    end

    typedef struct {
        logic [15:0] value;
        logic [7:0]  steps;
        logic        err;
        logic [15:0] peak;
        int          lat;
    } res_t;

    typedef struct {
        logic [15:0] value;
        logic [7:0]  steps;
        logic        err;
        logic [15:0] peak;
        int          lat;
        logic        busy0;
        logic        busy_end;
        logic        timeout;
    } obs_t;

    res_t        exp_q[$];
    logic [15:0] trace_q[$];
    int          cmp_cnt = 0;
    int          bad_cnt = 0;

    function automatic int w_of(input int i);
        return (i == 1) ? 8 : 16;
    endfunction

    function automatic int s_of(input int i);
        return (i == 2) ? 4 : 8;
    endfunction

    // Behavioural Collatz run with the block's termination rules
    function automatic res_t model(input int sd, input int w, input int s);
        res_t   r;
        longint v, pk, lim_v, lim_s;
        int     st;
        v = sd; pk = sd; st = 0;
        lim_v = (64'd1 << w) - 64'd1;
        lim_s = (64'd1 << s) - 64'd1;
        r.err = 1'b0;
        if (sd == 0) begin
            r.err = 1'b1;
            r.value = 16'd0; r.steps = 8'd0; r.peak = 16'd0; r.lat = 1;
            return r;
        end
        while (v != 1) begin
            if (st == lim_s) begin r.err = 1'b1; break; end
            if (v % 2 == 0) v = v / 2;
            else begin
                if (3 * v + 1 > lim_v) begin r.err = 1'b1; break; end
                v = 3 * v + 1;
            end
            st++;
            if (v > pk) pk = v;
        end
        r.value = v[15:0]; r.steps = st[7:0]; r.peak = pk[15:0]; r.lat = st + 2;
        return r;
    endfunction

    // Drives one start on instance idx, pushes the expectation, waits (bounded) for done
    task automatic run_seed(input int idx, input logic [7:0] sd, input bit pulse, output obs_t o);
        o = '{value: 16'd0, steps: 8'd0, err: 1'b0, peak: 16'd0, lat: 0,
              busy0: 1'b0, busy_end: 1'b0, timeout: 1'b1};
        trace_q.delete();
        @(posedge clk); #1;
        start_a[idx] = 1'b1;
        seed_a[idx]  = sd;
        exp_q.push_back(model(int'(sd), w_of(idx), s_of(idx)));
        for (int n = 1; n <= 400; n++) begin
            @(posedge clk); #1;
            start_a[idx] = 1'b0;
            if (n == 1) o.busy0 = busy_a[idx];
            if (pulse && n == 3) begin
                start_a[idx] = 1'b1;
                seed_a[idx]  = 8'd6;
            end
            trace_q.push_back(value_a[idx]);
            if (done_a[idx]) begin
                o.lat = n; o.value = value_a[idx]; o.steps = steps_a[idx];
                o.err = err_a[idx]; o.peak = peak_a[idx]; o.busy_end = busy_a[idx];
                o.timeout = 1'b0;
                break;
            end
        end
        start_a[idx] = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            cmp_cnt++;
            if ({busy_a[i], done_a[i], err_a[i], value_a[i], steps_a[i], peak_a[i]} !== 43'd0) begin
                bad_cnt++;
                $display("FAIL reset_state[%0d]: got busy=%b done=%b err=%b value=%0d steps=%0d, expected all 0",
                         i, busy_a[i], done_a[i], err_a[i], value_a[i], steps_a[i]);
            end
        end
    endtask

    task automatic test_seed6();
        obs_t o; res_t e;
        logic [15:0] walk [8] = '{16'd3, 16'd10, 16'd5, 16'd16, 16'd8, 16'd4, 16'd2, 16'd1};
        run_seed(0, 8'd6, 1'b0, o);
        e = exp_q.pop_front();
        cmp_cnt++;
        if (o.timeout !== 1'b0) begin bad_cnt++; $display("FAIL seed6_timeout: no done within bound"); end
        cmp_cnt++;
        if (o.steps !== e.steps || o.steps !== 8'd8) begin
            bad_cnt++; $display("FAIL seed6_steps: got %0d expected %0d", o.steps, e.steps);
        end
        cmp_cnt++;
        if (o.value !== 16'd1 || o.err !== 1'b0) begin
            bad_cnt++; $display("FAIL seed6_result: got value=%0d err=%b expected 1/0", o.value, o.err);
        end
        cmp_cnt++;
        if (o.lat !== 10) begin bad_cnt++; $display("FAIL seed6_latency: got %0d expected 10", o.lat); end
        cmp_cnt++;
        if (o.busy0 !== 1'b1 || o.busy_end !== 1'b0) begin
            bad_cnt++; $display("FAIL seed6_busy: got start=%b end=%b expected 1/0", o.busy0, o.busy_end);
        end
        for (int i = 0; i < 8; i++) begin
            cmp_cnt++;
            if (trace_q.size() < 9 || trace_q[i+1] !== walk[i]) begin
                bad_cnt++; $display("FAIL seed6_walk[%0d]: got %0d expected %0d", i,
                                    (trace_q.size() > i + 1) ? trace_q[i+1] : 16'hFFFF, walk[i]);
            end
        end
    endtask

    task automatic test_small_seeds();
        obs_t o; res_t e;
        run_seed(0, 8'd1, 1'b0, o);
        e = exp_q.pop_front();
        cmp_cnt++;
        if (o.timeout || o.value !== e.value || o.steps !== 8'd0 || o.err !== 1'b0 || o.lat !== 2) begin
            bad_cnt++; $display("FAIL seed1: got value=%0d steps=%0d err=%b lat=%0d expected 1/0/0/2",
                                o.value, o.steps, o.err, o.lat);
        end
        run_seed(0, 8'd0, 1'b0, o);
        e = exp_q.pop_front();
        cmp_cnt++;
        if (o.timeout || o.err !== e.err || o.err !== 1'b1 || o.steps !== 8'd0 || o.lat !== e.lat) begin
            bad_cnt++; $display("FAIL seed0: got err=%b steps=%0d lat=%0d expected 1/0/%0d",
                                o.err, o.steps, o.lat, e.lat);
        end
        cmp_cnt++;
        if (o.busy0 !== 1'b0) begin bad_cnt++; $display("FAIL seed0_busy: got %b expected 0", o.busy0); end
    endtask

    task automatic test_seed27();
        obs_t o; res_t e;
        run_seed(0, 8'd27, 1'b0, o);
        e = exp_q.pop_front();
        cmp_cnt++;
        if (o.timeout || o.steps !== 8'd111 || o.steps !== e.steps || o.value !== 16'd1 || o.err !== 1'b0) begin
            bad_cnt++; $display("FAIL seed27: got value=%0d steps=%0d err=%b expected 1/111/0",
                                o.value, o.steps, o.err);
        end
        cmp_cnt++;
        if (o.lat !== e.lat) begin bad_cnt++; $display("FAIL seed27_latency: got %0d expected %0d", o.lat, e.lat); end
`ifdef COLLATZ_PEAK_EN
        cmp_cnt++;
        if (o.peak !== 16'd9232 || o.peak !== e.peak) begin
            bad_cnt++; $display("FAIL seed27_peak: got %0d expected 9232", o.peak);
        end
`endif
    endtask

    task automatic test_overflow();
        obs_t o; res_t e;
        run_seed(1, 8'd27, 1'b0, o);
        e = exp_q.pop_front();
        cmp_cnt++;
        if (o.timeout || o.err !== 1'b1 || o.value !== 16'd107 || o.steps !== 8'd11 ||
            o.value !== e.value || o.steps !== e.steps) begin
            bad_cnt++; $display("FAIL overflow_w8: got value=%0d steps=%0d err=%b expected 107/11/1",
                                o.value, o.steps, o.err);
        end
    endtask

    task automatic test_saturation();
        obs_t o; res_t e;
        run_seed(2, 8'd27, 1'b0, o);
        e = exp_q.pop_front();
        cmp_cnt++;
        if (o.timeout || o.err !== 1'b1 || o.steps !== 8'd15 || o.value !== e.value || o.lat !== e.lat) begin
            bad_cnt++; $display("FAIL saturate_s4: got value=%0d steps=%0d err=%b lat=%0d expected %0d/15/1/%0d",
                                o.value, o.steps, o.err, o.lat, e.value, e.lat);
        end
    endtask

    task automatic test_start_ignored();
        obs_t o; res_t e;
        run_seed(2, 8'd27, 1'b1, o);
        e = exp_q.pop_front();
        cmp_cnt++;
        if (o.timeout || o.value !== e.value || o.steps !== e.steps || o.err !== e.err || o.lat !== e.lat) begin
            bad_cnt++; $display("FAIL start_while_busy: got value=%0d steps=%0d err=%b lat=%0d expected %0d/%0d/%b/%0d",
                                o.value, o.steps, o.err, o.lat, e.value, e.steps, e.err, e.lat);
        end
    endtask

    task automatic test_reset_midrun();
        obs_t o; res_t e;
        @(posedge clk); #1;
        start_a[0] = 1'b1; seed_a[0] = 8'd27;
        for (int n = 0; n < 5; n++) begin
            @(posedge clk); #1;
            start_a[0] = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        cmp_cnt++;
        if ({busy_m, done_m, err_m, value_m, steps_m, peak_a[0]} !== 43'd0) begin
            bad_cnt++; $display("FAIL reset_midrun: got busy=%b done=%b err=%b value=%0d steps=%0d, expected all 0",
                                busy_m, done_m, err_m, value_m, steps_m);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_seed(0, 8'd27, 1'b0, o);
        e = exp_q.pop_front();
        cmp_cnt++;
        if (o.timeout || o.value !== e.value || o.steps !== e.steps || o.err !== e.err || o.lat !== e.lat) begin
            bad_cnt++; $display("FAIL after_reset_run: got steps=%0d lat=%0d expected %0d/%0d",
                                o.steps, o.lat, e.steps, e.lat);
        end
    endtask

    task automatic test_back_to_back();
        obs_t o; res_t e;
        bit   seen = 1'b0;
        run_seed(0, 8'd1, 1'b0, o);
        e = exp_q.pop_front();
        cmp_cnt++;
        if (o.timeout || o.steps !== e.steps) begin
            bad_cnt++; $display("FAIL b2b_first: got steps=%0d expected %0d", o.steps, e.steps);
        end
        start_a[0] = 1'b1; seed_a[0] = 8'd6;
        exp_q.push_back(model(6, 16, 8));
        @(posedge clk); #1;
        cmp_cnt++;
        if (busy_m !== 1'b0 || done_m !== 1'b0) begin
            bad_cnt++; $display("FAIL b2b_start_in_done: got busy=%b done=%b expected 0/0", busy_m, done_m);
        end
        @(posedge clk); #1;
        start_a[0] = 1'b0;
        cmp_cnt++;
        if (busy_m !== 1'b1) begin bad_cnt++; $display("FAIL b2b_accept: got busy=%b expected 1", busy_m); end
        e = exp_q.pop_front();
        for (int n = 1; n <= 400; n++) begin
            if (done_m) begin
                seen = 1'b1;
                cmp_cnt++;
                if (n !== e.lat || steps_m !== e.steps || value_m !== e.value) begin
                    bad_cnt++; $display("FAIL b2b_second: got lat=%0d steps=%0d expected %0d/%0d",
                                        n, steps_m, e.lat, e.steps);
                end
                break;
            end
            @(posedge clk); #1;
        end
        if (!seen) begin
            cmp_cnt++; bad_cnt++;
            $display("FAIL b2b_timeout: no done within bound");
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            start_a[i] = 1'b0;
            seed_a[i]  = 8'd0;
        end
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        test_reset();
        test_seed6();
        test_small_seeds();
        test_seed27();
        test_overflow();
        test_saturation();
        test_start_ignored();
        test_reset_midrun();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, bad_cnt);
        $finish;
    end

endmodule
